// File: rtl/fpu_issue_ctrl.sv
// Single-issue sequencer for the vector FPU: hazard scoreboard, latency shift register, fence drain.
// Optional FPU_ISSUE_PERF_EN adds saturating issue/stall performance counters.
module fpu_issue_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int LEN         = 9,
    parameter int FPU_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  instr_fence,
    input  logic [7:0]            instr_opcode,
    input  logic [3:0]            instr_index,
    input  logic [LEN-1:0]        instr_predicate,
    input  logic [ADDR_WIDTH-1:0] instr_vd,
    input  logic [ADDR_WIDTH-1:0] instr_vs1,
    input  logic [ADDR_WIDTH-1:0] instr_vs2,
    input  logic [ADDR_WIDTH-1:0] instr_vs3,
    output logic [ADDR_WIDTH-1:0] rd_addr_n,
    output logic [ADDR_WIDTH-1:0] rd_addr_m,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic                  fpu_en,
    output logic [7:0]            fpu_opcode,
    output logic [3:0]            fpu_index,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [LEN-1:0]        wb_mask,
    output logic                  fence_done,
`ifdef FPU_ISSUE_PERF_EN
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [NUM_REGS-1:0]     sb_q, sb_d;
    logic [FPU_LATENCY-1:0]  pv_q;
    logic [ADDR_WIDTH-1:0]   pvd_q   [FPU_LATENCY];
    logic [LEN-1:0]          ppred_q [FPU_LATENCY];
    logic [7:0]              op_q;
    logic [3:0]              idx_q;

    logic                    hazard, fire, issue, fence_fire, retire, remaining;
    logic [FPU_LATENCY-1:0]  last_bit;

    assign last_bit   = FPU_LATENCY'(1) << (FPU_LATENCY - 1);
    // Slots that will still be in flight after the oldest one exits this cycle.
    assign remaining  = |(pv_q & ~last_bit);
    assign retire     = pv_q[FPU_LATENCY-1];

    assign hazard      = sb_q[instr_vs1] | sb_q[instr_vs2] | sb_q[instr_vs3] | sb_q[instr_vd];
    assign instr_ready = !rst && (state_q != DRAIN) && (instr_fence || !hazard);
    assign fire        = instr_valid && instr_ready;
    assign issue       = fire && !instr_fence;
    assign fence_fire  = fire && instr_fence;

    assign rd_addr_n  = instr_vs1;
    assign rd_addr_m  = instr_vs2;
    assign rd_addr_a  = instr_vs3;
    assign fpu_en     = issue;
    assign fpu_opcode = issue ? instr_opcode : op_q;
    assign fpu_index  = issue ? instr_index  : idx_q;

    assign wb_en      = retire && (|ppred_q[FPU_LATENCY-1]);
    assign wb_addr    = pvd_q[FPU_LATENCY-1];
    assign wb_mask    = retire ? ppred_q[FPU_LATENCY-1] : '0;
    assign fence_done = (state_q == DRAIN) && !remaining;
    assign busy       = (state_q != IDLE) || (|pv_q);

    // Set after clear so a retiring register re-claimed by a new writer stays busy.
    always_comb begin
        sb_d = sb_q;
        if (retire) sb_d[pvd_q[FPU_LATENCY-1]] = 1'b0;
        if (issue)  sb_d[instr_vd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sb_q    <= '0;
            pv_q    <= '0;
            op_q    <= '0;
            idx_q   <= '0;
        end else begin
            sb_q <= sb_d;
            for (int i = FPU_LATENCY - 1; i > 0; i--) pv_q[i] <= pv_q[i-1];
            pv_q[0] <= issue;
            if (issue) begin
                op_q  <= instr_opcode;
                idx_q <= instr_index;
            end
            case (state_q)
                IDLE:    if (fence_fire) state_q <= DRAIN;
                         else if (issue) state_q <= RUN;
                RUN:     if (fence_fire) state_q <= DRAIN;
                         else if (!issue && !remaining) state_q <= IDLE;
                DRAIN:   if (!remaining) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through the reset-cleared valid bits.
    for (genvar gi = 0; gi < FPU_LATENCY; gi++) begin : g_slot
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                pvd_q[gi]   <= instr_vd;
                ppred_q[gi] <= instr_predicate;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                pvd_q[gi]   <= pvd_q[gi-1];
                ppred_q[gi] <= ppred_q[gi-1];
            end
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] issued_q, stall_q;
    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (issue && (issued_q != 32'hFFFF_FFFF)) issued_q <= issued_q + 32'd1;
            if (instr_valid && !instr_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: expected writebacks/fence completions are queued at issue
// and checked by an independent monitor; directed vectors cover stream, RAW, WAW, predicate, fence, reset.
module tb_fpu_issue_ctrl;
    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready, instr_fence;
    logic [7:0] instr_opcode;
    logic [3:0] instr_index;
    logic [8:0] instr_predicate;
    logic [4:0] instr_vd, instr_vs1, instr_vs2, instr_vs3;
    logic [4:0] rd_addr_n, rd_addr_m, rd_addr_a;
    logic       fpu_en;
    logic [7:0] fpu_opcode;
    logic [3:0] fpu_index;
    logic       wb_en;
    logic [4:0] wb_addr;
    logic [8:0] wb_mask;
    logic       fence_done, busy;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    fpu_issue_ctrl #(.NUM_REGS(32), .ADDR_WIDTH(5), .LEN(9), .FPU_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_fence(instr_fence),
        .instr_opcode(instr_opcode), .instr_index(instr_index), .instr_predicate(instr_predicate),
        .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vs3(instr_vs3),
        .rd_addr_n(rd_addr_n), .rd_addr_m(rd_addr_m), .rd_addr_a(rd_addr_a),
        .fpu_en(fpu_en), .fpu_opcode(fpu_opcode), .fpu_index(fpu_index),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_mask(wb_mask), .fence_done(fence_done),
`ifdef FPU_ISSUE_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         c;
        logic [4:0] a;
        logic [8:0] m;
    } wb_t;
    wb_t wbq[$];
    int  fdq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback / fence_done must match the head of its expectation queue.
    always @(negedge clk) begin
        if (wb_en) begin
            if (wbq.size() == 0) chk("wb_unexpected", 32'(wb_en), 32'd0);
            else begin
                wb_t e;
                e = wbq.pop_front();
                chk("wb_cycle", cyc, e.c);
                chk("wb_addr", 32'(wb_addr), 32'(e.a));
                chk("wb_mask", 32'(wb_mask), 32'(e.m));
                $display("wb cycle %0d addr %0d mask %03h", cyc, wb_addr, wb_mask);
            end
        end else if (wbq.size() > 0 && wbq[0].c <= cyc) begin
            chk("wb_missing", 32'(wb_en), 32'd1);
            void'(wbq.pop_front());
        end
        if (fence_done) begin
            if (fdq.size() == 0) chk("fence_unexpected", 32'(fence_done), 32'd0);
            else chk("fence_cycle", cyc, fdq.pop_front());
        end else if (fdq.size() > 0 && fdq[0] <= cyc) begin
            chk("fence_missing", 32'(fence_done), 32'd1);
            void'(fdq.pop_front());
        end
    end

    task automatic send(input logic f, input logic [7:0] op, input logic [3:0] idx,
                        input logic [8:0] pred, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [4:0] vs3,
                        output int fc, output int stalls);
        instr_valid = 1'b1; instr_fence = f; instr_opcode = op; instr_index = idx;
        instr_predicate = pred; instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2; instr_vs3 = vs3;
        stalls = 0;
        fc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                fc = cyc;
                chk("fpu_en", 32'(fpu_en), 32'(!f));
                chk("rd_addr_n", 32'(rd_addr_n), 32'(vs1));
                if (!f) begin
                    chk("fpu_opcode", 32'(fpu_opcode), 32'(op));
                    chk("fpu_index", 32'(fpu_index), 32'(idx));
                    if (pred != 9'h0) wbq.push_back('{fc + L, vd, pred});
                end
                break;
            end
            stalls++;
            chk("fpu_en_stall", 32'(fpu_en), 32'd0);
        end
        if (fc < 0) chk("fire_timeout", 32'(instr_ready), 32'd1);
        $display("issue fence=%0d vd=%0d op=%02h cycle %0d stalls %0d", f, vd, op, fc, stalls);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        instr_fence = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fc, st, fa, f0;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] ps0, pi0;
`endif

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_fence = 1'b0; instr_opcode = '0; instr_index = '0;
        instr_predicate = '0; instr_vd = '0; instr_vs1 = '0; instr_vs2 = '0; instr_vs3 = '0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_fpu_en", 32'(fpu_en), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_mask", 32'(wb_mask), 32'd0);
        chk("rst_fence_done", 32'(fence_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Independent stream
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'h10 + 8'(i), 4'(i), 9'h1FF, 5'(i + 1), 5'd10, 5'd11, 5'd12, fc, st);
            if (i == 0) f0 = fc;
            chk("stream_stall", st, 0);
            chk("stream_cycle", fc, f0 + i);
        end
        idle(6);
        @(negedge clk);
        chk("stream_busy", 32'(busy), 32'd0);
        chk("opcode_hold", 32'(fpu_opcode), 32'h13);
        @(posedge clk); #1;

        // RAW
`ifdef FPU_ISSUE_PERF_EN
        ps0 = perf_stall; pi0 = perf_issued;
`endif
        send(1'b0, 8'h21, 4'h1, 9'h1FF, 5'd5, 5'd20, 5'd21, 5'd22, fa, st);
        send(1'b0, 8'h22, 4'h2, 9'h0F0, 5'd6, 5'd5, 5'd21, 5'd22, fc, st);
        chk("raw_stalls", st, 3);
        chk("raw_fire", fc, fa + 4);
`ifdef FPU_ISSUE_PERF_EN
        chk("perf_stall", perf_stall - ps0, 32'd3);
        chk("perf_issued", perf_issued - pi0, 32'd2);
`endif
        idle(5);

        // Predicate
        send(1'b0, 8'h31, 4'h3, 9'h000, 5'd7, 5'd20, 5'd21, 5'd22, fa, st);
        send(1'b0, 8'h32, 4'h4, 9'h1A5, 5'd8, 5'd20, 5'd7, 5'd22, fc, st);
        chk("pred_stalls", st, 3);
        idle(5);

        // Fence with two ops in flight
        send(1'b0, 8'h41, 4'h5, 9'h1FF, 5'd9, 5'd20, 5'd21, 5'd22, fa, st);
        send(1'b0, 8'h42, 4'h6, 9'h003, 5'd10, 5'd20, 5'd21, 5'd22, fc, st);
        fdq.push_back(fc + L);
        send(1'b1, 8'h00, 4'h0, 9'h000, 5'd0, 5'd9, 5'd10, 5'd0, f0, st);
        chk("fence_stall", st, 0);
        idle(0);
        @(negedge clk);
        chk("drain_ready", 32'(instr_ready), 32'd0);
        chk("drain_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("drain_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("drain_busy3", 32'(busy), 32'd0);
        chk("drain_ready_after", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;

        // Fence on empty pipe
        fdq.push_back(cyc + 1);
        send(1'b1, 8'h00, 4'h0, 9'h000, 5'd0, 5'd0, 5'd0, 5'd0, f0, st);
        idle(0);
        @(negedge clk);
        chk("efence_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("efence_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++)
            send(1'b0, 8'h50 + 8'(i), 4'(i), 9'h1FF, 5'(11 + i), 5'd20, 5'd21, 5'd22, fc, st);
        rst = 1'b1;
        instr_valid = 1'b0;
        wbq.delete();
        @(negedge clk);
        chk("mid_rst_ready", 32'(instr_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wb", 32'(wb_en), 32'd0);
`ifdef FPU_ISSUE_PERF_EN
        chk("mid_rst_perf", perf_issued, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        @(negedge clk);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send(1'b0, 8'h60, 4'h7, 9'h011, 5'd11, 5'd12, 5'd13, 5'd11, fc, st);
        chk("post_rst_stall", st, 0);
        idle(5);

        // WAW
        send(1'b0, 8'h71, 4'h8, 9'h1FF, 5'd3, 5'd20, 5'd21, 5'd22, fa, st);
        send(1'b0, 8'h72, 4'h9, 9'h0F0, 5'd3, 5'd24, 5'd25, 5'd26, fc, st);
        chk("waw_stalls", st, 3);
        idle(8);

        chk("wbq_drained", wbq.size(), 0);
        chk("fdq_drained", fdq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
